// File: rtl/bf16_seg_accumulator.sv
// bf16_seg_accumulator: reduces in_last-delimited groups of bf16 values to a
// single bf16 sum through one combinational bf16_adder, with a one-entry
// registered result behind a valid/ready handshake.
// Optional build macro: BF16_SEG_ACC_INF_FLAG_EN adds a sticky out_inf flag
// for groups that touched an exp==8'hFF operand or partial sum.

// Combinational bf16 adder: 2 guard bits, round-nearest-even, exact
// cancellation gives +0, exp 8'hFF treated as an ordinary exponent.
module bf16_adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);
  logic       sa, sb, swap, s_big, eff_sub, zero, ru;
  logic [7:0] ea_e, eb_e, ma, mb, e_big, e_sm, m_big, m_sm, d;
  logic [7:0] e_n, eo;
  logic [9:0] ml, ms, diff, m10;
  logic [10:0] add11;
  logic [8:0] mr;
  logic [6:0] frac;
  logic [3:0] lz;
  logic       lz_found;

  assign sa   = a[15];
  assign sb   = b[15];
  // Subnormals use an effective exponent of 1 and no hidden bit.
  assign ea_e = (a[14:7] == 8'd0) ? 8'd1 : a[14:7];
  assign eb_e = (b[14:7] == 8'd0) ? 8'd1 : b[14:7];
  assign ma   = {(a[14:7] != 8'd0), a[6:0]};
  assign mb   = {(b[14:7] != 8'd0), b[6:0]};

  // Order operands by magnitude so the subtraction never goes negative.
  assign swap    = {ea_e, ma} < {eb_e, mb};
  assign s_big   = swap ? sb : sa;
  assign e_big   = swap ? eb_e : ea_e;
  assign e_sm    = swap ? ea_e : eb_e;
  assign m_big   = swap ? mb : ma;
  assign m_sm    = swap ? ma : mb;
  assign d       = e_big - e_sm;
  assign eff_sub = sa ^ sb;

  assign ml    = {m_big, 2'b00};
  assign ms    = (d >= 8'd10) ? 10'd0 : ({m_sm, 2'b00} >> d);
  assign add11 = {1'b0, ml} + {1'b0, ms};
  assign diff  = ml - ms;

  // Leading-zero count of the difference, for renormalisation.
  always_comb begin
    lz       = 4'd0;
    lz_found = 1'b0;
    for (int i = 9; i >= 0; i--) begin
      if (!lz_found) begin
        if (diff[i]) lz_found = 1'b1;
        else         lz = lz + 4'd1;
      end
    end
  end

  // Align/add/normalise, then round to 8 significant bits.
  always_comb begin
    m10  = 10'd0;
    e_n  = 8'd0;
    zero = 1'b0;
    if (!eff_sub) begin
      if (add11[10]) begin
        m10 = add11[10:1];
        e_n = e_big + 8'd1;
      end else begin
        m10 = add11[9:0];
        e_n = e_big;
      end
    end else if (diff == 10'd0) begin
      zero = 1'b1;
    end else if ({4'd0, lz} < e_big) begin
      m10 = diff << lz;
      e_n = e_big - {4'd0, lz};
    end else begin
      // Underflow into the subnormal range: shift only as far as exp 1 allows.
      m10 = diff << (e_big - 8'd1);
      e_n = 8'd1;
    end
    ru = m10[1] & (m10[0] | m10[2]);
    mr = {1'b0, m10[9:2]} + {8'd0, ru};
    if (mr[8]) begin
      eo   = e_n + 8'd1;
      frac = 7'd0;
    end else begin
      eo   = mr[7] ? e_n : 8'd0;
      frac = mr[6:0];
    end
    sum = zero ? 16'h0000 : {s_big, eo, frac};
  end
endmodule

module bf16_seg_accumulator #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
`ifdef BF16_SEG_ACC_INF_FLAG_EN
  output logic             out_inf,
`endif
  output logic [CNT_W-1:0] out_count
);
  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  state_t           state;
  logic [15:0]      acc;
  logic [15:0]      sum_w;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;

  bf16_adder u_add (.a(acc), .b(in_data), .sum(sum_w));

  assign in_ready = (state != OUT);
  assign accept   = in_valid && in_ready;
  assign cnt_inc  = (&cnt) ? cnt : cnt + 1'b1;

`ifdef BF16_SEG_ACC_INF_FLAG_EN
  logic inf_acc, inf_res, in_inf, sum_inf;
  assign in_inf  = (in_data[14:7] == 8'hFF);
  assign sum_inf = (sum_w[14:7] == 8'hFF);
  assign out_inf = inf_res && out_valid;

  // Sticky per-group infinity/overflow tracking.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      inf_acc <= 1'b0;
      inf_res <= 1'b0;
    end else if (accept) begin
      if (state == IDLE) begin
        inf_acc <= in_inf;
        if (in_last) inf_res <= in_inf;
      end else begin
        inf_acc <= inf_acc | in_inf | sum_inf;
        if (in_last) inf_res <= inf_acc | in_inf | sum_inf;
      end
    end
  end
`endif

  // Group FSM: load first beat, accumulate, hold result until handoff.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= 16'h0000;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
      out_count <= '0;
    end else if (clear) begin
      state     <= IDLE;
      acc       <= 16'h0000;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          acc <= in_data;
          cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
          if (in_last) begin
            out_data  <= in_data;
            out_count <= {{(CNT_W-1){1'b0}}, 1'b1};
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            state <= ACCUM;
          end
        end
        ACCUM: if (accept) begin
          cnt <= cnt_inc;
          if (in_last) begin
            acc       <= 16'h0000;
            out_data  <= sum_w;
            out_count <= cnt_inc;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            acc <= sum_w;
          end
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bf16_seg_accumulator.sv
// Directed bench for bf16_seg_accumulator; all driving and sampling on the
// falling clock edge, expected values hand-computed bf16 sums.
module tb_bf16_seg_accumulator;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst, clear, in_valid, in_ready, in_last;
  logic             out_valid, out_ready;
  logic [15:0]      in_data, out_data;
  logic [CNT_W-1:0] out_count;
`ifdef BF16_SEG_ACC_INF_FLAG_EN
  logic             out_inf;
`endif
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bf16_seg_accumulator #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef BF16_SEG_ACC_INF_FLAG_EN
    .out_inf(out_inf),
`endif
    .out_count(out_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one beat for one cycle; returns on the falling edge after the edge.
  task automatic beat(input logic [15:0] d, input logic l);
    in_valid = 1'b1; in_data = d; in_last = l;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic [15:0] d, input logic [CNT_W-1:0] c);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_data"},  {16'd0, out_data}, {16'd0, d});
    chk({tag, "_count"}, {16'd0, out_count}, {16'd0, c});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_data"},  {16'd0, out_data}, 32'h0000);
    chk({tag, "_count"}, {16'd0, out_count}, 32'd0);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 16'h0; in_last = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_reset("reset");

    // Single-beat group returns the operand bit-exact.
    beat(16'h3F80, 1'b1);
    chk_res("single", 16'h3F80, 1);
    chk("single_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("single_handoff", {31'd0, out_valid}, 32'd0);

    // 1.0 + 2.0 = 3.0, result one cycle after the last beat.
    beat(16'h3F80, 1'b0);
    chk("acc_no_valid", {31'd0, out_valid}, 32'd0);
    beat(16'h4000, 1'b1);
    chk_res("sum3", 16'h4040, 2);
    @(negedge clk);

    // Exact cancellation, then 1.0 + 1.0.
    beat(16'h3F80, 1'b0);
    beat(16'hBF80, 1'b1);
    chk_res("cancel", 16'h0000, 2);
    @(negedge clk);
    beat(16'h3F80, 1'b0);
    beat(16'h3F80, 1'b1);
    chk_res("sum2", 16'h4000, 2);
    @(negedge clk);

    // Backpressure: result held, input beats refused.
    out_ready = 1'b0;
    beat(16'h3F80, 1'b0);
    beat(16'h4000, 1'b1);
    in_valid = 1'b1; in_data = 16'h4100; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk_res("bp_hold", 16'h4040, 2);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);

    // clear mid-group drops the partial sum.
    beat(16'h3F80, 1'b0);
    beat(16'h4000, 1'b0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    beat(16'h3F00, 1'b1);
    chk_res("clear_mid", 16'h3F00, 1);
    @(negedge clk);

    // clear while holding a result.
    out_ready = 1'b0;
    beat(16'h4000, 1'b1);
    chk_res("pre_clear_out", 16'h4000, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_out_valid", {31'd0, out_valid}, 32'd0);
    chk("clear_out_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;

    // rst during ACCUM.
    beat(16'h4000, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset("rst_accum");
    beat(16'h3F80, 1'b1);
    chk_res("after_rst_accum", 16'h3F80, 1);
    @(negedge clk);

    // rst during OUT, then a fresh group.
    out_ready = 1'b0;
    beat(16'h3F80, 1'b0);
    beat(16'h4000, 1'b1);
    chk_res("pre_rst_out", 16'h4040, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset("rst_out");
    out_ready = 1'b1;
    beat(16'h3F80, 1'b0);
    beat(16'h4000, 1'b1);
    chk_res("after_rst_out", 16'h4040, 2);
    @(negedge clk);

    // Overflow into exp 8'hFF propagates as an ordinary value.
    beat(16'h7F00, 1'b0);
    beat(16'h7F00, 1'b1);
    chk_res("ovf", 16'h7F80, 2);
`ifdef BF16_SEG_ACC_INF_FLAG_EN
    chk("ovf_inf", {31'd0, out_inf}, 32'd1);
    @(negedge clk);
    chk("inf_drop", {31'd0, out_inf}, 32'd0);
    beat(16'h3F80, 1'b1);
    chk("inf_cleared", {31'd0, out_inf}, 32'd0);
`endif
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
